hall_call_dispatcher: RTL and testbench

- Central scheduler for hall (floor) calls in the multi-car elevator system.
- Latches up/down hall-call presses per floor and assigns each pending call to exactly one car.
- Assignment uses a nearest-eligible-car rule with a round-robin tie-break, and is offered to the car over a valid/ack handshake.
- Sits between the floor-button inputs and the per-car controllers. It replaces ad-hoc broadcast of the button state with explicit ownership.

---
 rtl/hall_call_dispatcher.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_hall_call_dispatcher.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hall_call_dispatcher.sv
// -----------------------------------------------------------------------------
// hall_call_dispatcher
//
// Central scheduler for elevator hall calls. Latches up/down button presses per
// floor, walks the call slots one per cycle, and hands each pending, unowned
// call to exactly one car through a valid/ack handshake.
//
// Call slots: s < FLOORS is the up call at floor s, s >= FLOORS is the down
// call at floor s-FLOORS.
//
// Car selection for slot (f,d): among eligible cars (idle, or travelling in
// direction d and strictly approaching f), choose minimum |loc-f|. Ties go to
// the first car at or after the round-robin pointer, in cyclic order.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   i_hall_up         per-floor up press (top floor ignored)
//   i_hall_down       per-floor down press (ground floor ignored)
//   i_car_loc         packed car floors, car c at [c*FLOOR_BITS +: FLOOR_BITS]
//   i_car_dir         car travel direction, 1=UP
//   i_car_idle        car stopped, door closed, no internal requests
//   i_car_arrive      one-cycle pulse: car serviced (car_loc, car_dir)
//   o_assign_valid    one-hot offer to a car (or all zero)
//   o_assign_floor    floor of the offered call
//   o_assign_dir      direction of the offered call, 1=UP
//   i_assign_ack      car accepts the offer (only the offered car counts)
//   o_pending_up      registered up-call status
//   o_pending_down    registered down-call status
// -----------------------------------------------------------------------------
module hall_call_dispatcher #(
    parameter int FLOORS      = 4,
    parameter int CARS        = 3,
    parameter int FLOOR_BITS  = 2,
    parameter int ACK_TIMEOUT = 7
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [FLOORS-1:0]            i_hall_up,
    input  logic [FLOORS-1:0]            i_hall_down,
    input  logic [CARS*FLOOR_BITS-1:0]   i_car_loc,
    input  logic [CARS-1:0]              i_car_dir,
    input  logic [CARS-1:0]              i_car_idle,
    input  logic [CARS-1:0]              i_car_arrive,
    output logic [CARS-1:0]              o_assign_valid,
    output logic [FLOOR_BITS-1:0]        o_assign_floor,
    output logic                         o_assign_dir,
    input  logic [CARS-1:0]              i_assign_ack,
    output logic [FLOORS-1:0]            o_pending_up,
    output logic [FLOORS-1:0]            o_pending_down
);

    localparam int SLOTS     = 2 * FLOORS;
    localparam int SLOT_BITS = $clog2(SLOTS);
    localparam int CAR_BITS  = (CARS > 1) ? $clog2(CARS) : 1;
    localparam int TMO_BITS  = $clog2(ACK_TIMEOUT + 1);
    localparam int COST_BITS = FLOOR_BITS + 1;

    localparam logic [SLOT_BITS-1:0] LAST_SLOT = SLOT_BITS'(SLOTS - 1);
    localparam logic [CAR_BITS-1:0]  LAST_CAR  = CAR_BITS'(CARS - 1);
    localparam logic [TMO_BITS-1:0]  TMO_LAST  = TMO_BITS'(ACK_TIMEOUT - 1);

    typedef enum logic {
        ST_SCAN,
        ST_OFFER
    } state_t;

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_t                 r_state;
    logic [FLOORS-1:0]      r_pending_up;
    logic [FLOORS-1:0]      r_pending_down;
    logic [SLOTS-1:0]       r_assigned;
    logic [SLOT_BITS-1:0]   r_scan_ptr;
    logic [CAR_BITS-1:0]    r_rr_ptr;
    logic [CAR_BITS-1:0]    r_win;
    logic [TMO_BITS-1:0]    r_tmo;
    logic [CARS-1:0]        r_valid;
    logic [FLOOR_BITS-1:0]  r_floor;
    logic                   r_dir;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic [FLOORS-1:0]      w_clr_up;
    logic [FLOORS-1:0]      w_clr_dn;
    logic [SLOTS-1:0]       w_clr_slot;
    logic [SLOTS-1:0]       w_pend_slot;
    logic [SLOTS-1:0]       w_set_slot;
    logic [SLOTS-1:0]       w_asg_next;
    logic [FLOORS-1:0]      w_pend_up_next;
    logic [FLOORS-1:0]      w_pend_dn_next;

    logic                   w_slot_up;
    logic [FLOOR_BITS-1:0]  w_slot_floor;
    logic                   w_slot_open;

    logic [FLOOR_BITS-1:0]  w_loc  [CARS];
    logic [COST_BITS-1:0]   w_cost [CARS];
    logic [CARS-1:0]        w_elig;

    logic                   w_found;
    logic [CAR_BITS-1:0]    w_win;
    logic [CAR_BITS-1:0]    w_cand;
    logic [COST_BITS-1:0]   w_best;

    logic                   w_ack;
    logic                   w_offer_cleared;
    logic                   w_timeout;
    logic [SLOT_BITS-1:0]   w_scan_next;
    logic [CAR_BITS-1:0]    w_rr_next;

    // ------------------------------------------------------------------
    // Arrival clears: each arriving car retires the call matching its
    // floor and travel direction, whichever car owned it. Comparing
    // against every floor index keeps an out-of-range car_loc harmless.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every combinational output gets a default before any
        // conditional write, so no path leaves it holding a value (latch).
        w_clr_up = '0;
        w_clr_dn = '0;
        for (int c = 0; c < CARS; c++) begin
            for (int f = 0; f < FLOORS; f++) begin
                if (i_car_arrive[c] &&
                    (i_car_loc[c*FLOOR_BITS +: FLOOR_BITS] == FLOOR_BITS'(f))) begin
                    if (i_car_dir[c]) begin
                        w_clr_up[f] = 1'b1;
                    end else begin
                        w_clr_dn[f] = 1'b1;
                    end
                end
            end
        end
    end

    assign w_clr_slot  = {w_clr_dn, w_clr_up};
    assign w_pend_slot = {r_pending_down, r_pending_up};

    // ------------------------------------------------------------------
    // Decode the slot under the scan pointer.
    // ------------------------------------------------------------------
    assign w_slot_up    = (r_scan_ptr < SLOT_BITS'(FLOORS));
    assign w_slot_floor = w_slot_up ? FLOOR_BITS'(r_scan_ptr)
                                    : FLOOR_BITS'(r_scan_ptr - SLOT_BITS'(FLOORS));
    assign w_slot_open  = w_pend_slot[r_scan_ptr] && !r_assigned[r_scan_ptr];

    // ------------------------------------------------------------------
    // Per-car eligibility and distance for the scanned slot.
    // ------------------------------------------------------------------
    always_comb begin
        w_elig = '0;
        for (int c = 0; c < CARS; c++) begin
            w_loc[c]  = i_car_loc[c*FLOOR_BITS +: FLOOR_BITS];
            w_elig[c] = i_car_idle[c] ||
                        ((i_car_dir[c] == w_slot_up) &&
                         (w_slot_up ? (w_loc[c] < w_slot_floor)
                                    : (w_loc[c] > w_slot_floor)));
            // One extra bit so the subtraction is unsigned-safe.
            w_cost[c] = ({1'b0, w_loc[c]} >= {1'b0, w_slot_floor})
                      ? ({1'b0, w_loc[c]} - {1'b0, w_slot_floor})
                      : ({1'b0, w_slot_floor} - {1'b0, w_loc[c]});
        end
    end

    // ------------------------------------------------------------------
    // Winner search. Visiting cars in cyclic order from the round-robin
    // pointer and accepting only a strictly smaller cost makes the first
    // visited car win any tie.
    // ------------------------------------------------------------------
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_best  = '0;
        w_cand  = '0;
        for (int k = 0; k < CARS; k++) begin
            w_cand = CAR_BITS'((int'(r_rr_ptr) + k) % CARS);
            if (w_elig[w_cand] && (!w_found || (w_cost[w_cand] < w_best))) begin
                w_found = 1'b1;
                w_win   = w_cand;
                w_best  = w_cost[w_cand];
            end
        end
    end

    // ------------------------------------------------------------------
    // Offer bookkeeping.
    // ------------------------------------------------------------------
    assign w_ack           = i_assign_ack[r_win];
    assign w_offer_cleared = w_clr_slot[r_scan_ptr];
    assign w_timeout       = (r_tmo == TMO_LAST);
    assign w_scan_next     = (r_scan_ptr == LAST_SLOT) ? '0 : r_scan_ptr + SLOT_BITS'(1);
    assign w_rr_next       = (r_win == LAST_CAR) ? '0 : r_win + CAR_BITS'(1);

    // ------------------------------------------------------------------
    // Next pending / assigned state. A clear always beats a press or an
    // ack on the same slot in the same cycle.
    // ------------------------------------------------------------------
    always_comb begin
        w_pend_up_next = (r_pending_up   | i_hall_up)   & ~w_clr_up;
        w_pend_dn_next = (r_pending_down | i_hall_down) & ~w_clr_dn;
        // There is no up call from the top floor nor down call from floor 0.
        w_pend_up_next[FLOORS-1] = 1'b0;
        w_pend_dn_next[0]        = 1'b0;

        w_set_slot = '0;
        if ((r_state == ST_OFFER) && w_ack) begin
            w_set_slot[r_scan_ptr] = 1'b1;
        end
        w_asg_next = (r_assigned | w_set_slot) & ~w_clr_slot;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending_up   <= '0;
            r_pending_down <= '0;
            r_assigned     <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all
            // registers update together from the pre-edge values.
            r_pending_up   <= w_pend_up_next;
            r_pending_down <= w_pend_dn_next;
            r_assigned     <= w_asg_next;
        end
    end

    // ------------------------------------------------------------------
    // Scan / offer FSM with registered offer outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_SCAN;
            r_scan_ptr <= '0;
            r_rr_ptr   <= '0;
            r_win      <= '0;
            r_tmo      <= '0;
            r_valid    <= '0;
            r_floor    <= '0;
            r_dir      <= 1'b0;
        end else begin
            case (r_state)
                ST_SCAN: begin
                    if (w_slot_open && w_found) begin
                        r_state <= ST_OFFER;
                        r_win   <= w_win;
                        r_valid <= CARS'(1) << w_win;
                        r_floor <= w_slot_floor;
                        r_dir   <= w_slot_up;
                        r_tmo   <= '0;
                    end else begin
                        r_scan_ptr <= w_scan_next;
                    end
                end
                ST_OFFER: begin
                    if (w_ack) begin
                        r_state    <= ST_SCAN;
                        r_valid    <= '0;
                        r_rr_ptr   <= w_rr_next;
                        r_scan_ptr <= w_scan_next;
                    end else if (w_offer_cleared) begin
                        // Call already serviced by some car: withdraw.
                        r_state    <= ST_SCAN;
                        r_valid    <= '0;
                        r_scan_ptr <= w_scan_next;
                    end else if (w_timeout) begin
                        // Unresponsive car: give others a turn next time.
                        r_state    <= ST_SCAN;
                        r_valid    <= '0;
                        r_rr_ptr   <= w_rr_next;
                        r_scan_ptr <= w_scan_next;
                    end else begin
                        r_tmo <= r_tmo + TMO_BITS'(1);
                    end
                end
                default: begin
                    r_state <= ST_SCAN;
                    r_valid <= '0;
                end
            endcase
        end
    end

    assign o_assign_valid = r_valid;
    assign o_assign_floor = r_floor;
    assign o_assign_dir   = r_dir;
    assign o_pending_up   = r_pending_up;
    assign o_pending_down = r_pending_down;

endmodule

// File: tb/tb_hall_call_dispatcher.sv
// -----------------------------------------------------------------------------
// tb_hall_call_dispatcher
//
// Directed scenarios followed by a randomized run. Every cycle the DUT outputs
// are compared with a behavioural model that keeps the call table as plain
// arrays and picks the winning car by brute-force search.
// -----------------------------------------------------------------------------
module tb_hall_call_dispatcher;

    localparam int FLOORS      = 4;
    localparam int CARS        = 3;
    localparam int FB          = 2;
    localparam int ACK_TIMEOUT = 7;
    localparam int SLOTS       = 2 * FLOORS;

    logic                 clk;
    logic                 rst_n;
    logic [FLOORS-1:0]    hall_up;
    logic [FLOORS-1:0]    hall_down;
    logic [CARS*FB-1:0]   car_loc;
    logic [CARS-1:0]      car_dir;
    logic [CARS-1:0]      car_idle;
    logic [CARS-1:0]      car_arrive;
    logic [CARS-1:0]      assign_ack;
    logic [CARS-1:0]      assign_valid;
    logic [FB-1:0]        assign_floor;
    logic                 assign_dir;
    logic [FLOORS-1:0]    pending_up;
    logic [FLOORS-1:0]    pending_down;

    int total = 0;
    int bad   = 0;

    hall_call_dispatcher #(
        .FLOORS(FLOORS), .CARS(CARS), .FLOOR_BITS(FB), .ACK_TIMEOUT(ACK_TIMEOUT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .i_hall_up(hall_up),
        .i_hall_down(hall_down),
        .i_car_loc(car_loc),
        .i_car_dir(car_dir),
        .i_car_idle(car_idle),
        .i_car_arrive(car_arrive),
        .o_assign_valid(assign_valid),
        .o_assign_floor(assign_floor),
        .o_assign_dir(assign_dir),
        .i_assign_ack(assign_ack),
        .o_pending_up(pending_up),
        .o_pending_down(pending_down)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: call table, scan position, round-robin start and
    // the current offer (car, floor, direction, cycles left).
    // ------------------------------------------------------------------
    bit m_pu  [FLOORS];
    bit m_pd  [FLOORS];
    bit m_asg [SLOTS];
    int m_scan, m_rr, m_win, m_left, m_floor, m_dir;
    bit m_offer;

    function automatic int loc_of(int c);
        return int'(car_loc >> (c * FB)) & ((1 << FB) - 1);
    endfunction

    function automatic bit eligible(int c, int f, int d);
        int loc = loc_of(c);
        if (car_idle[c]) return 1'b1;
        if (int'(car_dir[c]) != d) return 1'b0;
        return (d == 1) ? (loc < f) : (loc > f);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < FLOORS; i++) begin
            m_pu[i] = 0;
            m_pd[i] = 0;
        end
        for (int s = 0; s < SLOTS; s++) m_asg[s] = 0;
        m_scan = 0; m_rr = 0; m_win = 0; m_left = 0;
        m_floor = 0; m_dir = 0; m_offer = 0;
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        bit clr [SLOTS];
        int set_s, f, d, s, c, best, best_cost, cost;
        for (int i = 0; i < SLOTS; i++) clr[i] = 0;
        for (int k = 0; k < CARS; k++) begin
            if (car_arrive[k]) begin
                f = loc_of(k);
                if (f < FLOORS) clr[car_dir[k] ? f : FLOORS + f] = 1;
            end
        end
        set_s = -1;
        if (!m_offer) begin
            s = m_scan;
            d = (s < FLOORS) ? 1 : 0;
            f = (d == 1) ? s : s - FLOORS;
            best = -1;
            best_cost = 0;
            if ((d == 1 ? m_pu[f] : m_pd[f]) && !m_asg[s]) begin
                for (int k = 0; k < CARS; k++) begin
                    c = (m_rr + k) % CARS;
                    if (eligible(c, f, d)) begin
                        cost = (loc_of(c) > f) ? loc_of(c) - f : f - loc_of(c);
                        if (best < 0 || cost < best_cost) begin
                            best = c;
                            best_cost = cost;
                        end
                    end
                end
            end
            if (best >= 0) begin
                m_offer = 1; m_win = best; m_floor = f; m_dir = d; m_left = ACK_TIMEOUT;
            end else begin
                m_scan = (m_scan + 1) % SLOTS;
            end
        end else if (assign_ack[m_win]) begin
            set_s = m_scan;
            m_rr = (m_win + 1) % CARS;
            m_scan = (m_scan + 1) % SLOTS;
            m_offer = 0;
        end else if (clr[m_scan]) begin
            m_scan = (m_scan + 1) % SLOTS;
            m_offer = 0;
        end else begin
            m_left--;
            if (m_left == 0) begin
                m_rr = (m_win + 1) % CARS;
                m_scan = (m_scan + 1) % SLOTS;
                m_offer = 0;
            end
        end
        for (int i = 0; i < SLOTS; i++) begin
            if (set_s == i) m_asg[i] = 1;
            if (clr[i]) m_asg[i] = 0;
        end
        for (int i = 0; i < FLOORS; i++) begin
            m_pu[i] = (i != FLOORS - 1) && !clr[i] && (m_pu[i] || hall_up[i]);
            m_pd[i] = (i != 0) && !clr[FLOORS + i] && (m_pd[i] || hall_down[i]);
        end
    endtask

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_model();
        logic [31:0] ev, eu, ed;
        ev = m_offer ? (32'd1 << m_win) : 32'd0;
        eu = 0;
        ed = 0;
        for (int i = 0; i < FLOORS; i++) begin
            eu[i] = m_pu[i];
            ed[i] = m_pd[i];
        end
        check("model_valid", 32'(assign_valid), ev);
        check("model_floor", 32'(assign_floor), 32'(m_floor));
        check("model_dir", 32'(assign_dir), 32'(m_dir));
        check("model_pend_up", 32'(pending_up), eu);
        check("model_pend_dn", 32'(pending_down), ed);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare_model();
    endtask

    task automatic clear_inputs();
        hall_up = '0; hall_down = '0; car_arrive = '0; assign_ack = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_valid", 32'(assign_valid), 0);
        check("reset_pend", 32'({pending_up, pending_down}), 0);
        check("reset_floor_dir", 32'({assign_floor, assign_dir}), 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic press_up(input int f);
        hall_up[f] = 1'b1;
        tick();
        hall_up = '0;
    endtask

    task automatic press_down(input int f);
        hall_down[f] = 1'b1;
        tick();
        hall_down = '0;
    endtask

    task automatic wait_offer(input int budget);
        for (int i = 0; i < budget && !m_offer; i++) tick();
    endtask

    task automatic ack_car(input int c);
        assign_ack = '0;
        assign_ack[c] = 1'b1;
        tick();
        assign_ack = '0;
        check("ack_drops_valid", 32'(assign_valid), 0);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int n;
        rst_n = 1'b0;
        car_loc = '0; car_dir = '0; car_idle = '0;
        clear_inputs();

        // 1: cars at 0,2,3 idle; up call at floor 1, tie broken toward car 0.
        car_loc = {2'd3, 2'd2, 2'd0}; car_idle = 3'b111; car_dir = 3'b111;
        do_reset();
        press_up(1);
        check("t1_pending", 32'(pending_up), 32'b0010);
        wait_offer(10);
        check("t1_valid", 32'(assign_valid), 32'b001);
        check("t1_floor_dir", 32'({assign_floor, assign_dir}), 32'({2'd1, 1'b1}));
        ack_car(0);

        // 2: two idle cars at floor 2 share two calls round-robin.
        car_loc = {2'd3, 2'd2, 2'd2}; car_idle = 3'b011; car_dir = 3'b100;
        do_reset();
        press_down(1);
        wait_offer(10);
        check("t2_first", 32'(assign_valid), 32'b001);
        check("t2_first_fd", 32'({assign_floor, assign_dir}), 32'({2'd1, 1'b0}));
        ack_car(0);
        press_down(3);
        wait_offer(10);
        check("t2_second", 32'(assign_valid), 32'b010);
        check("t2_second_fd", 32'({assign_floor, assign_dir}), 32'({2'd3, 1'b0}));
        ack_car(1);

        // 3: every car moving away from floor 2, then car 1 goes idle.
        car_loc = {2'd1, 2'd0, 2'd3}; car_idle = 3'b000; car_dir = 3'b001;
        do_reset();
        press_up(2);
        check("t3_pending", 32'(pending_up), 32'b0100);
        for (int i = 0; i < 9; i++) begin
            tick();
            check("t3_no_offer", 32'(assign_valid), 0);
        end
        car_idle = 3'b010;
        wait_offer(9);
        check("t3_offer", 32'(assign_valid), 32'b010);
        ack_car(1);

        // 4: timeout on car 2, then re-offer to car 0 after rr advances.
        car_loc = {2'd2, 2'd3, 2'd0}; car_idle = 3'b101; car_dir = 3'b010;
        do_reset();
        press_up(0);
        wait_offer(12);
        check("t4_setup", 32'(assign_valid), 32'b001);
        ack_car(0);
        press_up(1);
        wait_offer(12);
        n = 0;
        while (assign_valid === 3'b100 && n < 20) begin
            n++;
            tick();
        end
        check("t4_hold_cycles", 32'(n), ACK_TIMEOUT);
        check("t4_still_pending", 32'(pending_up), 32'b0011);
        wait_offer(20);
        check("t4_reoffer", 32'(assign_valid), 32'b001);
        check("t4_reoffer_fd", 32'({assign_floor, assign_dir}), 32'({2'd1, 1'b1}));
        ack_car(0);

        // 5: arrival clears the offered slot while the button is held.
        car_loc = {2'd3, 2'd3, 2'd0}; car_idle = 3'b111; car_dir = 3'b000;
        do_reset();
        press_up(1);
        wait_offer(10);
        check("t5_offer", 32'(assign_valid), 32'b001);
        car_loc = {2'd3, 2'd1, 2'd0}; car_dir = 3'b010;
        car_arrive = 3'b010; hall_up = 4'b0010;
        tick();
        car_arrive = '0; hall_up = '0;
        check("t5_cleared", 32'(pending_up), 0);
        check("t5_withdrawn", 32'(assign_valid), 0);
        for (int i = 0; i < 10; i++) tick();
        check("t5_not_reoffered", 32'(assign_valid), 0);

        // 6: asynchronous reset mid-offer, then ignored edge buttons.
        car_loc = {2'd3, 2'd2, 2'd0}; car_idle = 3'b111; car_dir = 3'b111;
        do_reset();
        press_up(1);
        wait_offer(10);
        check("t6_offer", 32'(assign_valid), 32'b001);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("t6_async_valid", 32'(assign_valid), 0);
        check("t6_async_pend", 32'({pending_up, pending_down}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        hall_up = 4'b1000; hall_down = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t6_ignored", 32'({pending_up, pending_down}), 0);
        end
        clear_inputs();

        // Randomized traffic checked every cycle against the model.
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            hall_up    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
            hall_down  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
            car_loc    = 6'($urandom);
            car_dir    = 3'($urandom);
            car_idle   = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b0;
            car_arrive = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'b0;
            assign_ack = ($urandom_range(0, 4) == 0) ? 3'($urandom) : 3'b0;
            tick();
        end
        clear_inputs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
